if_fetch: RTL
=============

# if_fetch

Instruction-fetch (IF) stage of the five-stage MIPS pipeline. It owns the PC register, issues fetch requests to the synchronous instruction SRAM, and produces `if_to_id_bus` for the decode stage. It consumes the decode stage's `br_bus` redirect, which is the other end of that interface. It honours the pipeline stall vector and holds any redirect that arrives while the PC is frozen, so no taken branch is lost during a stall.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: address of the first instruction fetched after reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-low (0 = reset asserted).
- `stall` input `StallBus` (6): pipeline stall vector. Bit 0 freezes the PC; `Stop`=1, `NoStop`=0.
- `br_bus` input 33: `{br_e, br_addr[31:0]}` from decode; `br_e`=1 means redirect the next fetch to `br_addr`.
- `if_to_id_bus` output 33 (`IF_TO_ID_WD`): `{ce, pc[31:0]}`; `ce`=1 marks a valid fetch at `pc`.
- `inst_sram_en` output 1: fetch request enable.
- `inst_sram_wen` output 4: always 4'b0000.
- `inst_sram_addr` output 32: fetch address.
- `inst_sram_wdata` output 32: always 32'b0.

## Operation
- **State:**
  - `pc_reg[31:0]`, `ce_reg`
  - `pend_valid`, `pend_addr[31:0]`: the held redirect.
- **Reset** (`rst`=0 at an edge):
  - `pc_reg` <= `RESET_PC` − 4 (32'hBFBF_FFFC at the default).
  - `ce_reg` <= 0, `pend_valid` <= 0, `pend_addr` <= 0.
  - Any reset mid-operation discards a held redirect.
- **Next-PC select** (combinational), priority high to low:
  1. `br_e`=1 → `br_addr`
  2. `pend_valid`=1 → `pend_addr`
  3. otherwise `pc_reg` + 4, 32-bit wrap-around (32'hFFFF_FFFC + 4 = 0).
- **Run** (`rst`=1, `stall[0]`=`NoStop`):
  - `pc_reg` <= next_pc, `ce_reg` <= 1, `pend_valid` <= 0.
- **Freeze** (`rst`=1, `stall[0]`=`Stop`):
  - `pc_reg` and `ce_reg` hold.
  - If `br_e`=1: `pend_valid` <= 1 and `pend_addr` <= `br_addr`. A later `br_e` during the same freeze overwrites the held address, because decode re-presents the same branch while stalled.
  - If `br_e`=0: the pending registers hold.
- **Stall release with live `br_e`:** the live `br_addr` wins over `pend_addr`, and the pending state clears.
- **Outputs:**
  - `inst_sram_en` = `ce_reg`.
  - `inst_sram_addr` = `pc_reg`.
  - `if_to_id_bus` = `{ce_reg, pc_reg}`.
  - The fetched word appears on `inst_sram_rdata` one cycle later and is consumed by decode.
- **Branch address:** not checked for alignment; `br_addr[1:0]` passes through unchanged.
- **Delay slot:** needs no special logic. When decode raises `br_e` for a branch at P, `pc_reg` already holds P+4, so the delay slot is fetched naturally.

## Timing
- **Reset values of outputs:**
  - `if_to_id_bus` = {1'b0, `RESET_PC` − 4}
  - `inst_sram_en` = 0
  - `inst_sram_addr` = `RESET_PC` − 4
  - `wen` = 0, `wdata` = 0
- **First edge after release** (unstalled): `pc_reg` = `RESET_PC`, `ce`=1.
- **Redirect latency:** `br_e` sampled at edge t gives `pc_reg` = `br_addr` after edge t, i.e. one cycle.
- **Freeze:** outputs are bit-for-bit stable for every cycle `stall[0]`=`Stop`.
- **Held redirect:** takes effect on the first edge with `stall[0]`=`NoStop`. No extra cycle of latency versus an unstalled redirect.
- **Bus timing:** no combinational path from `br_bus` or `stall` to any output; all outputs come from registers.

## Test plan
- **Reset release:** hold `rst`=0 for 3 cycles, then release with no stall. Expect `en`=0 and `addr`=BFBF_FFFC during reset; then addresses BFC0_0000, BFC0_0004, BFC0_0008 with `ce`=1.
- **Unstalled redirect:** with `pc_reg`=BFC0_0010, pulse `br_bus`={1, BFC0_0100} for one cycle. Next address is BFC0_0100, then BFC0_0104.
- **Redirect during freeze:** hold `stall[0]`=1 for 3 cycles at pc BFC0_0020 and pulse `br_e` to 8000_0040 in cycle 1 only. Address stays BFC0_0020 for the 3 cycles, then becomes 8000_0040 on release.
- **Overwrite and live-wins:**
  - During a freeze, send `br_e`→A then `br_e`→B; release. PC becomes B.
  - Separately: pending A, then `br_e`→C in the release cycle. PC becomes C, and the next PC is C+4, not A.
- **Reset mid-freeze:** with a pending redirect, assert `rst`=0 for one cycle. PC returns to the reset sequence (BFC0_0000 first) and the pending target is never fetched.
- **Wrap-around:** redirect to FFFF_FFFC, unstalled. Next fetch is 0000_0000; `wen`=0 and `wdata`=0 throughout.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM request and
// holds a decode redirect that arrives while the PC is frozen.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata
);

  localparam logic STOP = 1'b1;

  logic        br_e;
  logic [31:0] br_addr;
  assign {br_e, br_addr} = br_bus;

  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] next_pc;

  // Only bit 0 of the stall vector concerns this stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  // A live redirect beats a held one: decode re-presents the same branch on release.
  always_comb begin
    if (br_e)              next_pc = br_addr;
    else if (pend_valid_q) next_pc = pend_addr_q;
    else                   next_pc = pc_q + 32'd4;
  end

  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latch).
    pc_d         = pc_q;
    ce_d         = ce_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    if (stall[0] == STOP) begin
      if (br_e) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = br_addr;
      end
    end else begin
      pc_d         = next_pc;
      ce_d         = 1'b1;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      pc_q         <= RESET_PC - 32'd4;
      ce_q         <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      ce_q         <= ce_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign if_to_id_bus    = {ce_q, pc_q};
  assign inst_sram_en    = ce_q;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;

endmodule
